// File: rtl/stream_pkg.sv
// Shared types and constants for the RGB888 streaming pixel stages.
// Provides pixel/channel widths, the video packet identifier and the rgb_t bundle.
package stream_pkg;

    localparam int          PIX_W        = 8;
    localparam int          RGB_W        = 3 * PIX_W;
    localparam logic [3:0]  VIDEO_PKT_ID = 4'h0;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/pix_tap121.sv
// Combinational 3-tap [1 2 1]/4 smoothing of one 8-bit channel with rounding.
// Ports: h2 (older), h1 (previous), p (current) in; out = (h2 + 2*h1 + p + 2) >> 2.
module pix_tap121
    import stream_pkg::*;
(
    input  logic [PIX_W-1:0] h2,
    input  logic [PIX_W-1:0] h1,
    input  logic [PIX_W-1:0] p,
    output logic [PIX_W-1:0] out
);

    // Worst case 255 + 510 + 255 + 2 = 1022 fits in PIX_W+2 bits,
    // and the shifted result never exceeds 255.
    logic [PIX_W+1:0] sum;

    assign sum = {2'b00, h2}
               + {1'b0, h1, 1'b0}
               + {2'b00, p}
               + (PIX_W+2)'(2);

    assign out = sum[PIX_W+1:2];

endmodule

// File: rtl/stream_hsmooth.sv
// Avalon-ST RGB888 causal horizontal [1 2 1]/4 smoother with a single output register.
// Ports: clk, reset_n (sync, active-low); sink_* / source_* streams; enable; frame_count.
module stream_hsmooth
    import stream_pkg::*;
#(
    parameter int IMAGE_W = 640,
    parameter int DATA_W  = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sink_data,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic              sink_sop,
    input  logic              sink_eop,
    output logic [DATA_W-1:0] source_data,
    output logic              source_valid,
    input  logic              source_ready,
    output logic              source_sop,
    output logic              source_eop,
    input  logic              enable,
    output logic [7:0]        frame_count
);

    localparam int             XW     = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
    localparam logic [XW-1:0]  X_LAST = XW'(IMAGE_W - 1);

    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              sop_q,     sop_d;
    logic              eop_q,     eop_d;
    logic [7:0]        frame_q,   frame_d;
    logic [XW-1:0]     x_q,       x_d;
    logic              video_q,   video_d;
    logic              en_lat_q,  en_lat_d;
    rgb_t              h1_q,      h1_d;
    rgb_t              h2_q,      h2_d;

    logic acc;
    logic video_now;
    logic filt_on;
    rgb_t pix;
    rgb_t tap_h1;
    rgb_t tap_h2;
    rgb_t filt;

    assign sink_ready = source_ready | ~valid_q;
    assign acc        = sink_valid & sink_ready;

    assign pix = rgb_t'(sink_data[RGB_W-1:0]);

    // A single-beat packet must see its own packet type before the EOP count.
    assign video_now = sink_sop ? (sink_data[3:0] == VIDEO_PKT_ID) : video_q;
    assign filt_on   = ~sink_sop & video_q & en_lat_q;

    // Edge replication: at x==0 both history taps are the current pixel,
    // at x==1 the older tap reuses the previous pixel.
    always_comb begin
        tap_h1 = h1_q;
        tap_h2 = h2_q;
        if (x_q == '0) begin
            tap_h1 = pix;
            tap_h2 = pix;
        end else if (x_q == XW'(1)) begin
            tap_h2 = h1_q;
        end
    end

    pix_tap121 u_tap_r (
        .h2  (tap_h2.r),
        .h1  (tap_h1.r),
        .p   (pix.r),
        .out (filt.r)
    );

    pix_tap121 u_tap_g (
        .h2  (tap_h2.g),
        .h1  (tap_h1.g),
        .p   (pix.g),
        .out (filt.g)
    );

    pix_tap121 u_tap_b (
        .h2  (tap_h2.b),
        .h1  (tap_h1.b),
        .p   (pix.b),
        .out (filt.b)
    );

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        frame_d  = frame_q;
        x_d      = x_q;
        video_d  = video_q;
        en_lat_d = en_lat_q;
        h1_d     = h1_q;
        h2_d     = h2_q;

        if (acc) begin
            valid_d = 1'b1;
            sop_d   = sink_sop;
            eop_d   = sink_eop;
            data_d  = sink_data;
            if (filt_on) begin
                data_d = DATA_W'(filt);
            end

            if (sink_sop) begin
                // enable is latched once per packet so a frame is never split.
                video_d  = (sink_data[3:0] == VIDEO_PKT_ID);
                en_lat_d = enable;
                x_d      = '0;
            end else begin
                x_d  = (x_q == X_LAST) ? '0 : x_q + XW'(1);
                h2_d = h1_q;
                h1_d = pix;
            end

            if (sink_eop && video_now) begin
                frame_d = frame_q + 8'd1;
            end
        end else if (source_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            frame_q  <= '0;
            x_q      <= '0;
            video_q  <= 1'b0;
            en_lat_q <= 1'b0;
            h1_q     <= '0;
            h2_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            frame_q  <= frame_d;
            x_q      <= x_d;
            video_q  <= video_d;
            en_lat_q <= en_lat_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
        end
    end

    assign source_valid = valid_q;
    assign source_data  = data_q;
    assign source_sop   = sop_q;
    assign source_eop   = eop_q;
    assign frame_count  = frame_q;

endmodule
